pixel_capture: RTL

- Receiving end of the pixel stream produced by the ROM-based pixel feeder (valid/pixel/done interface).
- Captures one raster frame of 8-bit pixels into an internal frame buffer and tracks column and row position.
- Flags when the frame is complete, or when extra pixels arrive after completion.
- Exposes a synchronous read port so the LiteX CSR or host side can read the frame back after the convolution chain has run.

---
 rtl/pixel_capture.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pixel_capture.sv
// Captures one IMG_W x IMG_H frame of 8-bit pixels into block RAM and exposes a registered readback port.
// Optional running checksum is enabled by defining PIXEL_CAPTURE_CKSUM_EN; otherwise checksum is tied to zero.
module pixel_capture #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 960,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              valid_in,
    input  logic [7:0]        px_in,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [15:0]       col,
    output logic [15:0]       row,
    output logic [ADDR_W-1:0] pix_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam int                FRAME     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
    localparam logic [ADDR_W:0]   FRAME_SZ  = (ADDR_W + 1)'(FRAME);
    localparam logic [15:0]       COL_LAST  = 16'(IMG_W - 1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [15:0]       col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        mem_q [0:FRAME-1];
    logic              accept_s, arm_s;

    // Start only re-arms outside CAPTURE; a pixel in the arming cycle is dropped.
    assign accept_s = (state_q == S_CAPTURE) && valid_in;
    assign arm_s    = start && (state_q != S_CAPTURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CAPTURE;
                else       state_d = S_IDLE;
            end
            S_CAPTURE: begin
                if (accept_s && (pc_q == LAST_ADDR)) state_d = S_DONE;
                else                                  state_d = S_CAPTURE;
            end
            S_DONE: begin
                if (start) state_d = S_CAPTURE;
                else       state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        pc_d  = pc_q;
        ovf_d = ovf_q;
        if (arm_s) begin
            col_d = 16'd0;
            row_d = 16'd0;
            pc_d  = '0;
            ovf_d = 1'b0;
        end else if (accept_s) begin
            pc_d = pc_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
                col_d = 16'd0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
                row_d = row_q;
            end
        end else if ((state_q == S_DONE) && valid_in) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        if ({1'b0, rd_addr} < FRAME_SZ) rd_data_d = mem_q[rd_addr];
        else                            rd_data_d = 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            col_q     <= 16'd0;
            row_q     <= 16'd0;
            pc_q      <= '0;
            rd_data_q <= 8'd0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pc_q      <= pc_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Frame buffer write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept_s) mem_q[pc_q] <= px_in;
    end

`ifdef PIXEL_CAPTURE_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;

    always_comb begin
        if (arm_s)         cksum_d = 32'd0;
        else if (accept_s) cksum_d = cksum_q + {24'd0, px_in};
        else               cksum_d = cksum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cksum_q <= 32'd0;
        else     cksum_q <= cksum_d;
    end

    assign checksum = cksum_q;
`else
    assign checksum = 32'd0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign col       = col_q;
    assign row       = row_q;
    assign pix_count = pc_q;
    assign rd_data   = rd_data_q;

endmodule
